// File: rtl/fetch_buffer.sv
// Fetch stage between the program counter and decode.
// Issues in-order instruction reads, tags each request with its pc, and
// returns {pc, instruction} pairs to decode through a small response buffer.
// A flush empties the buffer and arranges for in-flight responses to be dropped.
module fetch_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc,
    input  logic              pc_valid,
    output logic              pc_ready,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [DATA_W-1:0] imem_rdata,
    input  logic              flush,
    output logic              instr_valid,
    output logic [DATA_W-1:0] instr_data,
    output logic [ADDR_W-1:0] instr_pc,
    input  logic              instr_ready,
    output logic              protocol_err
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    // Tag FIFO: pc of every granted request, popped as its response returns.
    logic [ADDR_W-1:0] r_tag_mem [DEPTH];
    logic [PW-1:0]     r_tag_wr;
    logic [PW-1:0]     r_tag_rd;
    logic [CW-1:0]     r_outst;
    logic [CW-1:0]     r_discard;
    logic              r_protocol_err;

    // Response buffer presented to decode.
    logic [DATA_W-1:0] r_buf_data [DEPTH];
    logic [ADDR_W-1:0] r_buf_pc   [DEPTH];
    logic [PW-1:0]     r_buf_wr;
    logic [PW-1:0]     r_buf_rd;
    logic [CW-1:0]     r_occ;

    logic [CW:0]       w_inflight;
    logic              w_credit;
    logic              w_req;
    logic              w_grant;
    logic              w_resp;
    logic              w_drop;
    logic              w_push;
    logic              w_pop;
    logic [CW-1:0]     w_outst_after_resp;

    // A request only issues when a buffer slot is guaranteed for its response.
    assign w_inflight = {1'b0, r_occ} + {1'b0, r_outst};
    assign w_credit   = w_inflight < (CW+1)'(DEPTH);
    // Requests are held off while reset is asserted so every output reads 0.
    assign w_req      = ~rst & pc_valid & w_credit & ~flush;
    assign w_grant    = w_req & imem_gnt;

    // A response with nothing outstanding is ignored (and flagged below).
    assign w_resp     = imem_rvalid & (r_outst != '0);
    assign w_drop     = flush | (r_discard != '0);
    assign w_push     = w_resp & ~w_drop;
    assign w_pop      = instr_valid & instr_ready & ~flush;

    assign w_outst_after_resp = r_outst - CW'(w_resp);

    assign imem_req     = w_req;
    assign imem_addr    = pc;
    assign pc_ready     = w_grant;
    assign instr_valid  = (r_occ != '0);
    assign instr_data   = r_buf_data[r_buf_rd];
    assign instr_pc     = r_buf_pc[r_buf_rd];
    assign protocol_err = r_protocol_err;

    // Tag storage write: record the pc of each granted request.
    // NOTE: this array has no reset; only the pointers decide which entries are live.
    always_ff @(posedge clk) begin
        if (w_grant) begin
            r_tag_mem[r_tag_wr] <= pc;
        end
    end

    // Request bookkeeping: tag pointers, outstanding count, discard count, error flag.
    // NOTE: state uses non-blocking assignments so every update sees pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tag_wr       <= '0;
            r_tag_rd       <= '0;
            r_outst        <= '0;
            r_discard      <= '0;
            r_protocol_err <= 1'b0;
        end else begin
            if (w_grant) begin
                r_tag_wr <= r_tag_wr + PW'(1);
            end
            if (w_resp) begin
                r_tag_rd <= r_tag_rd + PW'(1);
            end
            r_outst <= w_outst_after_resp + CW'(w_grant);
            // Every response still owed after this cycle belongs to the squashed path.
            if (flush) begin
                r_discard <= w_outst_after_resp;
            end else if (w_resp && (r_discard != '0)) begin
                r_discard <= r_discard - CW'(1);
            end
            if (imem_rvalid && (r_outst == '0)) begin
                r_protocol_err <= 1'b1;
            end
        end
    end

    // Response buffer: push kept responses, pop on decode, empty on flush.
    // NOTE: the storage is reset here because decode must see instr_data/instr_pc = 0 after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_buf_wr <= '0;
            r_buf_rd <= '0;
            r_occ    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_buf_data[i] <= '0;
                r_buf_pc[i]   <= '0;
            end
        end else if (flush) begin
            r_buf_wr <= '0;
            r_buf_rd <= '0;
            r_occ    <= '0;
        end else begin
            if (w_push) begin
                r_buf_data[r_buf_wr] <= imem_rdata;
                r_buf_pc[r_buf_wr]   <= r_tag_mem[r_tag_rd];
                r_buf_wr             <= r_buf_wr + PW'(1);
            end
            if (w_pop) begin
                r_buf_rd <= r_buf_rd + PW'(1);
            end
            r_occ <= r_occ + CW'(w_push) - CW'(w_pop);
        end
    end

endmodule

// File: tb/tb_fetch_buffer.sv
// Self-checking bench for fetch_buffer: directed scenarios followed by a
// randomized phase, all compared every cycle against a queue-based model.
module tb_fetch_buffer;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc;
    logic        pc_valid;
    logic        pc_ready;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        flush;
    logic        instr_valid;
    logic [31:0] instr_data;
    logic [31:0] instr_pc;
    logic        instr_ready;
    logic        protocol_err;

    fetch_buffer #(.DEPTH(DEPTH), .ADDR_W(32), .DATA_W(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .pc          (pc),
        .pc_valid    (pc_valid),
        .pc_ready    (pc_ready),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .flush       (flush),
        .instr_valid (instr_valid),
        .instr_data  (instr_data),
        .instr_pc    (instr_pc),
        .instr_ready (instr_ready),
        .protocol_err(protocol_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
    } ent_t;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: decode-visible entries, pcs awaiting a response,
    // responses still to be thrown away, and the sticky error.
    ent_t        m_buf[$];
    logic [31:0] m_tag[$];
    int          m_discard;
    bit          m_perr;

    // Memory stub: addresses granted and not yet answered.
    // mem_mode 0 = silent, 1 = answer next cycle, 2 = answer randomly, 3 = spurious rvalid.
    logic [31:0] mem_q[$];
    int          mem_mode;

    int          cyc = 0;
    bit          obs_grant;
    bit          obs_valid;
    bit          obs_pop;
    logic [31:0] obs_pc;
    logic [31:0] obs_data;
    logic [31:0] obs_addr;

    function automatic logic [31:0] data_of(input logic [31:0] a);
        return (a == 32'h100) ? 32'hBEEF : a + 32'hA0;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_clear();
        m_buf.delete();
        m_tag.delete();
        m_discard = 0;
        m_perr    = 1'b0;
    endtask

    function automatic bit model_req();
        return !rst && pc_valid && (m_buf.size() + m_tag.size() < DEPTH) && !flush;
    endfunction

    task automatic compare();
        bit req;
        req = model_req();
        check("imem_req", imem_req, req);
        check("pc_ready", pc_ready, req && imem_gnt);
        if (req) check("imem_addr", imem_addr, pc);
        check("instr_valid", instr_valid, m_buf.size() > 0);
        if (m_buf.size() > 0) begin
            check("instr_pc", instr_pc, m_buf[0].pc);
            check("instr_data", instr_data, m_buf[0].data);
        end
        check("protocol_err", protocol_err, m_perr);
    endtask

    // Advance model and memory stub across one rising edge using current inputs.
    task automatic model_update();
        bit          grant;
        logic [31:0] t;
        ent_t        e;
        if (rst) begin
            model_clear();
            return;
        end
        grant = model_req() && imem_gnt;
        if (imem_rvalid && m_tag.size() == 0) m_perr = 1'b1;
        if (m_buf.size() > 0 && instr_ready && !flush) void'(m_buf.pop_front());
        if (imem_rvalid && m_tag.size() > 0) begin
            t = m_tag.pop_front();
            if (flush) begin
                // dropped; discard is recomputed below
            end else if (m_discard > 0) begin
                m_discard--;
            end else begin
                e.pc   = t;
                e.data = imem_rdata;
                m_buf.push_back(e);
            end
        end
        if (flush) begin
            m_buf.delete();
            m_discard = m_tag.size();
        end
        if (grant) m_tag.push_back(pc);
        if (imem_rvalid && mem_q.size() > 0) void'(mem_q.pop_front());
        if (grant) mem_q.push_back(pc);
    endtask

    // One cycle: drive memory, check, update the model, move to the next falling edge.
    task automatic tick();
        bit have;
        have = mem_q.size() > 0;
        case (mem_mode)
            1:       imem_rvalid = have;
            2:       imem_rvalid = have && ($urandom_range(0, 1) == 1);
            3:       imem_rvalid = 1'b1;
            default: imem_rvalid = 1'b0;
        endcase
        if (rst) imem_rvalid = 1'b0;
        imem_rdata = have ? data_of(mem_q[0]) : $urandom;
        #1;
        if (rst) model_clear();
        compare();
        obs_grant = pc_ready;
        obs_valid = instr_valid;
        obs_pop   = instr_valid && instr_ready;
        obs_pc    = instr_pc;
        obs_data  = instr_data;
        obs_addr  = imem_addr;
        model_update();
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic drain();
        flush       = 1'b0;
        pc_valid    = 1'b0;
        instr_ready = 1'b1;
        mem_mode    = 1;
        for (int i = 0; i < 40 && (m_buf.size() > 0 || m_tag.size() > 0 || mem_q.size() > 0); i++) tick();
        tick();
    endtask

    initial begin
        int          g;
        int          g2;
        int          first_grant;
        int          first_valid;
        bit          found;
        logic [31:0] exp_pc[$];
        ent_t        got[$];
        int          got_cyc[$];
        ent_t        e;

        rst         = 1'b1;
        pc          = 32'h0;
        pc_valid    = 1'b1;
        imem_gnt    = 1'b1;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        flush       = 1'b0;
        instr_ready = 1'b0;
        mem_mode    = 0;
        model_clear();

        // Reset state (pc_valid high to show requests are held off).
        #1;
        check("rst_instr_valid", instr_valid, 0);
        check("rst_instr_data", instr_data, 0);
        check("rst_instr_pc", instr_pc, 0);
        check("rst_imem_req", imem_req, 0);
        check("rst_pc_ready", pc_ready, 0);
        check("rst_protocol_err", protocol_err, 0);
        @(negedge clk);
        tick();
        rst = 1'b0;

        // Streaming: three fetches, one-cycle memory, decode always ready.
        pc = 32'h0; pc_valid = 1'b1; imem_gnt = 1'b1; instr_ready = 1'b1; mem_mode = 1;
        g = 0; first_grant = -1; first_valid = -1;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (obs_valid && first_valid < 0) first_valid = cyc - 1;
            if (obs_pop) begin
                e.pc = obs_pc; e.data = obs_data;
                got.push_back(e);
                got_cyc.push_back(cyc - 1);
            end
            if (obs_grant) begin
                if (first_grant < 0) first_grant = cyc - 1;
                g++;
                pc = pc + 32'h4;
                if (g == 3) pc_valid = 1'b0;
            end
        end
        check("stream_count", got.size(), 3);
        check("stream_latency", first_valid - first_grant, 2);
        for (int k = 0; k < 3 && k < got.size(); k++) begin
            check("stream_pc", got[k].pc, 32'(k * 4));
            check("stream_data", got[k].data, 32'hA0 + 32'(k * 4));
            if (k > 0) check("stream_consecutive", got_cyc[k] - got_cyc[k-1], 1);
        end
        drain();

        // Backpressure: decode stalled, credit must stop requests at DEPTH.
        pc = 32'h200; pc_valid = 1'b1; instr_ready = 1'b0; imem_gnt = 1'b1; mem_mode = 1;
        g = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (obs_grant) begin g++; pc = pc + 32'h4; end
        end
        #1;
        check("bp_grants", g, DEPTH);
        check("bp_imem_req_off", imem_req, 0);
        check("bp_pc_ready_off", pc_ready, 0);
        instr_ready = 1'b1;
        got.delete();
        g2 = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (obs_pop) begin e.pc = obs_pc; e.data = obs_data; got.push_back(e); end
            if (obs_grant) begin g2++; pc = pc + 32'h4; end
        end
        check("bp_pop_count_ge4", got.size() >= 4, 1);
        for (int k = 0; k < 4 && k < got.size(); k++) begin
            check("bp_order_pc", got[k].pc, 32'h200 + 32'(k * 4));
            check("bp_order_data", got[k].data, 32'h2A0 + 32'(k * 4));
        end
        check("bp_resume", g2 > 0, 1);
        drain();

        // Memory stall: grant withheld, address must hold and nothing is buffered.
        pc = 32'h300; pc_valid = 1'b1; imem_gnt = 1'b0; mem_mode = 1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_pc_ready", obs_grant, 0);
            check("stall_addr", obs_addr, 32'h300);
            check("stall_no_entry", obs_valid, 0);
        end
        pc_valid = 1'b0; imem_gnt = 1'b1;
        drain();

        // Flush with three requests in flight and one entry buffered.
        pc = 32'h400; pc_valid = 1'b1; instr_ready = 1'b0; imem_gnt = 1'b1;
        mem_mode = 0; tick(); if (obs_grant) pc = pc + 32'h4;
        mem_mode = 1; tick(); if (obs_grant) pc = pc + 32'h4;
        mem_mode = 0; tick(); if (obs_grant) pc = pc + 32'h4;
        tick(); if (obs_grant) pc = pc + 32'h4;
        pc_valid = 1'b0;
        check("fl_setup_head", instr_pc, 32'h400);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("fl_valid_off", instr_valid, 0);
        pc = 32'h100; pc_valid = 1'b1; instr_ready = 1'b1; mem_mode = 1;
        found = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (obs_grant) pc_valid = 1'b0;
            if (obs_valid && !found) begin
                found = 1'b1;
                check("fl_first_pc", obs_pc, 32'h100);
                check("fl_first_data", obs_data, 32'hBEEF);
            end
        end
        check("fl_first_seen", found, 1);
        drain();

        // Flush in the same cycle as a response and a decode pop.
        pc = 32'h500; pc_valid = 1'b1; instr_ready = 1'b0; imem_gnt = 1'b1;
        mem_mode = 0; tick(); if (obs_grant) pc = pc + 32'h4;
        mem_mode = 1; tick(); if (obs_grant) pc = pc + 32'h4;
        mem_mode = 0; tick(); if (obs_grant) pc = pc + 32'h4;
        pc_valid = 1'b0; instr_ready = 1'b1; mem_mode = 1; flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flc_valid_off", instr_valid, 0);
        tick();
        check("flc_late_dropped", instr_valid, 0);
        pc = 32'h600; pc_valid = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (obs_grant) pc_valid = 1'b0;
            if (obs_valid && !found) begin
                found = 1'b1;
                check("flc_first_pc", obs_pc, 32'h600);
                check("flc_first_data", obs_data, 32'h6A0);
            end
        end
        check("flc_first_seen", found, 1);
        drain();

        // Randomized traffic with occasional flushes.
        mem_mode = 2;
        pc = 32'h1000;
        for (int i = 0; i < 400; i++) begin
            pc_valid    = ($urandom_range(0, 3) != 0);
            imem_gnt    = ($urandom_range(0, 9) < 7);
            instr_ready = ($urandom_range(0, 9) < 7);
            flush       = ($urandom_range(0, 99) < 8);
            tick();
            if (obs_grant) pc = $urandom & 32'hFFFF_FFFC;
        end
        drain();

        // Spurious response with nothing outstanding.
        check("sp_before", protocol_err, 0);
        mem_mode = 3;
        tick();
        mem_mode = 0;
        check("sp_set", protocol_err, 1);
        tick(); tick(); tick();
        check("sp_sticky", protocol_err, 1);

        // Asynchronous reset in the middle of streaming.
        pc = 32'h700; pc_valid = 1'b1; instr_ready = 1'b0; imem_gnt = 1'b1; mem_mode = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (obs_grant) pc = pc + 32'h4;
        end
        check("mr_busy_valid", instr_valid, 1);
        rst = 1'b1;
        #1;
        check("mr_instr_valid", instr_valid, 0);
        check("mr_instr_data", instr_data, 0);
        check("mr_instr_pc", instr_pc, 0);
        check("mr_imem_req", imem_req, 0);
        check("mr_pc_ready", pc_ready, 0);
        check("mr_protocol_err", protocol_err, 0);
        tick();
        rst = 1'b0;
        pc_valid = 1'b0;
        mem_mode = 1;
        tick();
        tick();
        check("mr_late_response_err", protocol_err, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
